// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buf.sv
// Small synchronous FIFO of {pc, inst} entries; flush overrides push and pop.
module fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic            do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full buffer is legal only when the head leaves the same cycle
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM and feeds decode through fetch_buf.
// state | meaning
// BOOT  | one idle cycle after reset release, ce=0
// RUN   | fetching while buffer has room or head is leaving
// HALT  | stopped on a misaligned redirect target, waits for an aligned redirect
module inst_fetch
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ce,
  output logic [XLEN-1:0]   addr,
  input  logic [INST_W-1:0] inst,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              misalign,
  output logic [XLEN-1:0]   misalign_pc
);
  fetch_state_t  state, state_nxt;
  logic [XLEN-1:0] pc;
  logic          full, empty, push, pop, redir_ok, aligned;
  fetch_entry_t  head, wdata;

  assign aligned  = (redirect_pc[1:0] == 2'b00);
  assign redir_ok = redirect & (state != BOOT);
  assign pop      = id_valid & id_ready;
  assign push     = ce & ~redirect;
  assign addr     = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     state_nxt = RUN;
      RUN,
      HALT:     if (redirect) state_nxt = aligned ? RUN : HALT;
      default:  state_nxt = BOOT;
    endcase
  end

  always_comb begin
    ce = 1'b0;
    if (state == RUN) ce = ~full | pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      misalign_pc <= '0;
    end else if (redir_ok) begin
      if (aligned) begin
        pc       <= redirect_pc;
        misalign <= 1'b0;
      end else begin
        misalign    <= 1'b1;
        misalign_pc <= redirect_pc;
      end
    end else if (push) begin
      pc <= pc + PC_INC;
    end
  end

  always_comb begin
    wdata      = '0;
    wdata.pc   = pc;
    wdata.inst = inst;
  end

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redir_ok),
    .wdata (wdata),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign id_valid = ~empty;
  assign id_pc    = head.pc;
  assign id_inst  = head.inst;
endmodule
